// File: rtl/design_08_result_buf.sv
// Result FIFO behind design_08: ready/valid out, overflow/drop status.
// Optional same-cycle bypass when empty: DESIGN_08_RESULT_BUF_BYPASS_EN.
module design_08_result_buf #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic fifo_valid;
  logic full;
  logic byp;
  logic byp_take;
  logic pop;
  logic push;
  logic drop;

  assign fifo_valid = (level != '0);
  assign full       = (level == FULL);

`ifdef DESIGN_08_RESULT_BUF_BYPASS_EN
  assign byp      = ~fifo_valid & in_valid;
  assign byp_take = byp & out_ready;
`else
  assign byp      = 1'b0;
  assign byp_take = 1'b0;
`endif

  assign out_valid = fifo_valid | byp;

  always_comb begin
    out_data = '0;
    if (fifo_valid)
      out_data = mem[rd_ptr];
    else if (byp)
      out_data = in_data;
  end

  // Only a registered head counts as a FIFO pop; a bypass take never enters.
  assign pop  = fifo_valid & out_ready;
  assign push = in_valid & (~full | pop) & ~byp_take;
  assign drop = in_valid & full & ~pop;

  always_ff @(posedge clk) begin
    if (push && !rst)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // A drop in the clr cycle still records itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr)
        drop_cnt <= CNT_W'(1);
      else if (drop_cnt != CNT_MAX)
        drop_cnt <= drop_cnt + CNT_W'(1);
    end else if (clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_design_08_result_buf.sv
// Scoreboard bench for design_08_result_buf.
// Stimulus tasks feed a queue model; a negedge monitor checks outputs.
module tb_design_08_result_buf;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [$clog2(DEPTH):0] level;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;
  logic             clr;

  always #5 clk = ~clk;

  design_08_result_buf #(
    .W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .level(level),
    .overflow(overflow),
    .drop_cnt(drop_cnt),
    .clr(clr)
  );

  int checks = 0;
  int passes = 0;

  logic [W-1:0] sb_q [$];
  int m_lvl = 0;
  int m_ov  = 0;
  int m_cnt = 0;

  bit           stall  = 1'b0;
  logic [W-1:0] hold_d = '0;

`ifdef DESIGN_08_RESULT_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp)
      passes++;
    else
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
  endtask

  task automatic step(input bit r, input bit iv,
                      input logic [W-1:0] d,
                      input bit rd, input bit cl);
    bit pop, byp, acc, drp;
    int lvl0;
    rst = r; in_valid = iv; in_data = d;
    out_ready = rd; clr = cl;
    lvl0 = m_lvl;
    if (r) begin
      sb_q.delete();
      m_lvl = 0; m_ov = 0; m_cnt = 0;
    end else begin
      pop  = (m_lvl > 0) && rd;
      byp  = BYP && (m_lvl == 0) && iv && rd;
      acc  = iv && ((m_lvl < DEPTH) || pop);
      drp  = iv && !acc;
      if (acc) sb_q.push_back(d);
      m_lvl = m_lvl + ((acc && !byp) ? 1 : 0) - (pop ? 1 : 0);
      if (drp) begin
        m_ov  = 1;
        m_cnt = cl ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
      end else if (cl) begin
        m_ov = 0; m_cnt = 0;
      end
      #2;
      chk("pre_valid", 32'(out_valid),
          32'((lvl0 > 0) || (BYP && iv)));
      if (BYP && iv && lvl0 == 0)
        chk("bypass_data", 32'(out_data), 32'(d));
    end
    @(posedge clk);
    #1;
    chk("level", 32'(level), 32'(m_lvl));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(hold_d));
      end
      if (!out_valid) begin
        chk("idle_data", 32'(out_data), 32'd0);
      end else if (out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_out: got %0h expected none",
                   out_data);
        end else begin
          chk("data", 32'(out_data), 32'(sb_q.pop_front()));
        end
      end
      stall  = out_valid && !out_ready;
      hold_d = out_data;
    end
  end

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && m_lvl > 0; i++)
      step(0, 0, '0, 1, 0);
    chk("drained", 32'(m_lvl), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; clr = 1'b0;

    step(1, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);

    step(0, 1, 16'h1234, 0, 0);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'h1234);
    step(0, 0, '0, 1, 0);
    chk("pop_valid", 32'(out_valid), 32'd0);

    for (int i = 1; i <= 4; i++)
      step(0, 1, W'(i), 0, 0);
    step(0, 1, 16'd5, 0, 0);
    step(0, 1, 16'd6, 0, 0);
    chk("full_head", 32'(out_data), 32'd1);
    chk("ovf_cnt2", 32'(drop_cnt), 32'd2);
    step(0, 0, '0, 0, 1);
    chk("clr_level", 32'(level), 32'd4);

    step(0, 1, 16'd9, 1, 0);
    drain();

    for (int i = 0; i < 20; i++)
      step(0, 1, W'(16'h100 + i), 1, 0);
    drain();

    for (int i = 0; i < 4; i++)
      step(0, 1, W'($urandom), 0, 0);
    for (int i = 0; i < 300; i++)
      step(0, 1, W'($urandom), 0, 0);
    chk("sat_cnt", 32'(drop_cnt), 32'hFF);
    step(0, 1, 16'h55, 0, 1);
    step(0, 0, '0, 0, 1);
    drain();

    for (int i = 0; i < 3; i++)
      step(0, 1, W'(16'h30 + i), 0, 0);
    step(1, 1, 16'h77, 0, 0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    step(0, 0, '0, 1, 0);

    step(0, 1, 16'hBEEF, 1, 0);
    step(0, 0, '0, 1, 0);

    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 99) == 0,
           ($urandom % 4) != 0,
           W'($urandom),
           $urandom_range(0, 99) < 55,
           $urandom_range(0, 49) == 0);
    drain();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
